// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, opcode enum and default widths for the accumulator CPU
package cpu_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;
  typedef enum logic [2:0] {
    HLT = OP_HLT,
    SKZ = OP_SKZ,
    ADD = OP_ADD,
    AND = OP_AND,
    XOR = OP_XOR,
    LDA = OP_LDA,
    STO = OP_STO,
    JMP = OP_JMP
  } opcode_e;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational accumulator ALU, passes a through for non-arithmetic opcodes
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  always_comb
    y = opcode == OP_ADD ? a + b :
        opcode == OP_AND ? a & b :
        opcode == OP_XOR ? a ^ b :
        opcode == OP_LDA ? b : a;
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: phase sequencer plus IR/PC/AC registers, ALU and memory port of the accumulator CPU
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              rd,
  input  logic              ld_ir,
  input  logic              halt,
  input  logic              inc_pc,
  input  logic              ld_ac,
  input  logic              wr,
  input  logic              ld_pc,
  input  logic              data_e,
  output logic [2:0]        phase,
  output logic [2:0]        opcode,
  output logic              zero,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [DATA_W-1:0] ir, ac, alu_y;
  cpu_alu #(.DATA_W(DATA_W)) u_alu (.opcode(opcode), .a(ac), .b(mem_rdata), .y(alu_y));
  always_ff @(posedge clk)
    if (rst) begin
      phase  <= '0;
      halted <= 1'b0;
      ir     <= '0;
      pc     <= '0;
      ac     <= '0;
    end else if (!halted) begin
      if (halt) halted <= 1'b1;
      else phase <= phase + 3'd1;
      if (ld_ir) ir <= mem_rdata;
      if (ld_pc) pc <= ir[ADDR_W-1:0];
      else if (inc_pc) pc <= pc + ADDR_W'(1);
      if (ld_ac) ac <= alu_y;
    end
  assign opcode       = ir[DATA_W-1 -: 3];
  assign zero         = ac == '0;
  assign mem_addr     = sel ? pc : ir[ADDR_W-1:0];
  assign mem_rd       = rd;
  assign mem_wr       = wr;
  assign mem_wdata    = ac;
  assign mem_wdata_oe = data_e;
endmodule
